regbank_wr_arb: RTL and testbench

REGBANK_WR_ARB -- requirements
Module: regbank_wr_arb

---
 rtl/regbank_pkg.sv | 13 +
 rtl/regbank_wr_arb_rr_pick.sv | 26 ++
 rtl/regbank_wr_arb.sv | 155 +++++++++++++++
 tb/tb_regbank_wr_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and widths for the register-bank write path.
package regbank_pkg;

    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_COUNT = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/regbank_wr_arb_rr_pick.sv
// Round-robin priority picker: one-hot grant to the first requester found
// when searching upward from ptr_i, wrapping at N_REQ-1.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    always_comb begin
        logic found;
        gnt_o = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && req_i[i] && (i == (32'(ptr_i) + k) % N_REQ)) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arb.sv
// Write-port arbiter for a small register bank: round-robin across requesters,
// with optional locked bursts of up to MAX_BURST back-to-back writes.
module regbank_wr_arb
    import regbank_pkg::*;
#(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [REG_IDX_W*N_REQ-1:0] req_dr,
    input  logic [DATA_W*N_REQ-1:0]    req_data,
    input  logic                       stall,
    output logic [N_REQ-1:0]           gnt,
    output logic                       write,
    output logic [REG_IDX_W-1:0]       dr,
    output logic [DATA_W-1:0]          wrData,
    output logic                       busy
);

    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 4;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 write_q;
    logic [REG_IDX_W-1:0] dr_q;
    logic [DATA_W-1:0]    data_q;

    logic [N_REQ-1:0]     rr_gnt;
    logic [N_REQ-1:0]     own_gnt;
    logic                 own_req;
    logic                 own_lock;
    logic                 accept;
    logic [PTR_W-1:0]     sel_idx;
    logic                 sel_lock;
    logic [REG_IDX_W-1:0] sel_dr;
    logic [DATA_W-1:0]    sel_data;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        return (32'(idx) == N_REQ - 1) ? '0 : idx + PTR_W'(1);
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_gnt  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(owner_q) == i) begin
                own_req    = req[i];
                own_lock   = lock[i];
                own_gnt[i] = 1'b1;
            end
        end
        // Grant is forced low while reset is held, not just after the edge.
        gnt = '0;
        if (rst_n && !stall) begin
            if (state_q == ST_IDLE) begin
                gnt = rr_gnt;
            end else if (own_req) begin
                gnt = own_gnt;
            end
        end
    end

    assign accept = |gnt;

    always_comb begin
        sel_idx  = '0;
        sel_lock = 1'b0;
        sel_dr   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_idx  = PTR_W'(i);
                sel_lock = lock[i];
                sel_dr   = req_dr[REG_IDX_W*i +: REG_IDX_W];
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ptr_d = wrap_inc(sel_idx);
                        if (sel_lock && (MAX_BURST > 1)) begin
                            state_d = ST_LOCKED;
                            owner_d = sel_idx;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Burst ends when the owner goes quiet, drops lock, or hits MAX_BURST.
                    if (!accept || !own_lock || (32'(cnt_q) + 1 >= MAX_BURST)) begin
                        state_d = ST_IDLE;
                        ptr_d   = wrap_inc(owner_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            dr_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            write_q <= accept;
            if (accept) begin
                dr_q   <= sel_dr;
                data_q <= sel_data;
            end
        end
    end

    assign write  = write_q;
    assign dr     = dr_q;
    assign wrData = data_q;
    assign busy   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_regbank_wr_arb.sv
// Randomized and directed bench for regbank_wr_arb against a behavioural
// arbiter/regbank model.
module tb_regbank_wr_arb;

    localparam int N    = 3;
    localparam int MAXB = 4;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            stall    = 1'b0;
    logic [N-1:0]    req      = '0;
    logic [N-1:0]    lock     = '0;
    logic [2*N-1:0]  req_dr   = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]    gnt;
    logic            write;
    logic [1:0]      dr;
    logic [31:0]     wrData;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_locked;
    int          m_ptr, m_owner, m_cnt;
    logic        exp_write;
    logic [1:0]  exp_dr;
    logic [31:0] exp_data;
    logic [31:0] bank_mdl [4];
    logic [31:0] bank_dut [4];
    logic [N-1:0] last_gnt;

    regbank_wr_arb #(
        .N_REQ     (N),
        .MAX_BURST (MAXB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .req_dr   (req_dr),
        .req_data (req_data),
        .stall    (stall),
        .gnt      (gnt),
        .write    (write),
        .dr       (dr),
        .wrData   (wrData),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic set_slot(input int i, input logic [1:0] d, input logic [31:0] v);
        req_dr   = (req_dr & ~((2*N)'(3) << (2*i))) | ((2*N)'(d) << (2*i));
        req_data = (req_data & ~((32*N)'(32'hFFFF_FFFF) << (32*i))) | ((32*N)'(v) << (32*i));
    endtask

    function automatic int model_pick();
        int idx;
        if (stall) return -1;
        if (m_locked) return bit_at(req, m_owner) ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (bit_at(req, idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked  = 1'b0;
        m_ptr     = 0;
        m_owner   = 0;
        m_cnt     = 0;
        exp_write = 1'b0;
        exp_dr    = '0;
        exp_data  = '0;
    endtask

    // Called at posedge+1; asserts reset asynchronously and checks outputs clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_write", 32'(write), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dr", 32'(dr), 32'h0);
        chk("rst_wrData", wrData, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_gnt", 32'(gnt), 32'h0);
        rst_n = 1'b1;
    endtask

    // Inputs are set by the caller at posedge+1; one full clock is checked.
    task automatic do_cycle();
        int              g;
        logic [N-1:0]    eg;
        logic [2*N-1:0]  tdr;
        logic [32*N-1:0] tdat;
        @(negedge clk);
        g  = model_pick();
        eg = '0;
        if (g >= 0) eg = N'(1) << g;
        chk("gnt", 32'(gnt), 32'(eg));
        last_gnt = gnt;
        @(posedge clk);
        if (stall) begin
            exp_write = 1'b0;
        end else if (g >= 0) begin
            tdr       = req_dr >> (2*g);
            tdat      = req_data >> (32*g);
            exp_write = 1'b1;
            exp_dr    = tdr[1:0];
            exp_data  = tdat[31:0];
            bank_mdl[exp_dr] = exp_data;
            if (!m_locked) begin
                m_ptr = (g + 1) % N;
                if (bit_at(lock, g) && MAXB > 1) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_cnt    = 1;
                end
            end else begin
                m_cnt++;
                if (!bit_at(lock, g) || m_cnt == MAXB) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
        end else begin
            exp_write = 1'b0;
            if (m_locked) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
        #1;
        chk("write", 32'(write), 32'(exp_write));
        chk("dr", 32'(dr), 32'(exp_dr));
        chk("wrData", wrData, exp_data);
        chk("busy", 32'(busy), 32'(m_locked));
        if (write) bank_dut[dr] = wrData;
    endtask

    initial begin
        int exp_seq [6];
        int exp_bsy [6];
        exp_seq = '{2, 2, 2, 2, 4, 1};
        exp_bsy = '{1, 1, 1, 0, 0, 0};
        for (int r = 0; r < 4; r++) begin
            bank_mdl[r] = '0;
            bank_dut[r] = '0;
        end
        model_reset();
        req = 3'b111;
        set_slot(0, 2'd0, 32'h1111_0000);
        set_slot(1, 2'd1, 32'h2222_0001);
        set_slot(2, 2'd2, 32'h3333_0002);
        @(posedge clk);
        #1;
        do_reset();

        // Plain round-robin across all three
        do_cycle(); chk("rr_g0", 32'(last_gnt), 32'h1);
        chk("rr_wdata0", wrData, 32'h1111_0000);
        do_cycle(); chk("rr_g1", 32'(last_gnt), 32'h2);
        do_cycle(); chk("rr_g2", 32'(last_gnt), 32'h4);
        chk("rr_dr2", 32'(dr), 32'h2);

        // Wrap from the top requester back to 0
        req = 3'b101;
        do_cycle(); chk("wrap_g0", 32'(last_gnt), 32'h1);
        req = 3'b100;
        do_cycle(); chk("wrap_g2", 32'(last_gnt), 32'h4);
        req = 3'b111;
        do_cycle(); chk("wrap_ptr0", 32'(last_gnt), 32'h1);

        // Locked burst from requester 1 capped at MAX_BURST
        req  = 3'b111;
        lock = 3'b010;
        for (int c = 0; c < 6; c++) begin
            do_cycle();
            chk("burst_gnt", 32'(last_gnt), 32'(exp_seq[c]));
            chk("burst_busy", 32'(busy), 32'(exp_bsy[c]));
        end

        // Stall freezes everything
        lock  = '0;
        req   = 3'b011;
        stall = 1'b1;
        do_cycle(); chk("stall_gnt", 32'(last_gnt), 32'h0); chk("stall_wr", 32'(write), 32'h0);
        do_cycle(); chk("stall_gnt", 32'(last_gnt), 32'h0); chk("stall_wr", 32'(write), 32'h0);
        stall = 1'b0;
        do_cycle(); chk("stall_resume", 32'(last_gnt), 32'h2);

        // Reset in the middle of a locked burst
        req  = 3'b001;
        lock = 3'b001;
        do_cycle();
        do_cycle();
        chk("lk_busy", 32'(busy), 32'h1);
        do_reset();
        req  = 3'b010;
        lock = '0;
        do_cycle(); chk("post_rst_g", 32'(last_gnt), 32'h2);

        // Same destination from two requesters: no merging, grant order wins
        do_reset();
        req = 3'b101;
        set_slot(0, 2'd3, 32'hAAAA_0000);
        set_slot(2, 2'd3, 32'h5555_FFFF);
        do_cycle(); chk("same_dr_g0", 32'(last_gnt), 32'h1);
        req = 3'b100;
        do_cycle(); chk("same_dr_g2", 32'(last_gnt), 32'h4);
        req = 3'b000;
        do_cycle();
        chk("r3_read", bank_dut[3], 32'h5555_FFFF);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            req   = N'($urandom) | N'($urandom);
            lock  = N'($urandom) | N'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) set_slot(i, 2'($urandom), $urandom);
            if (c == 300) do_reset();
            do_cycle();
        end
        req   = '0;
        stall = 1'b0;
        do_cycle();
        for (int r = 0; r < 4; r++) chk("bank_final", bank_dut[r], bank_mdl[r]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
